// File: rtl/sel_scan_ctrl.sv
// Channel scanner for a 4:1 selector: walks enabled channels in ascending order,
// dwells on each, and captures the selector output into a per-channel sample bit.
module sel_scan_ctrl #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       mux_in,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);

    typedef enum logic [0:0] {StIdle, StScan} state_t;

    localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

    state_t        state;
    logic [3:0]    mask_lat;
    logic [CW-1:0] cnt;

    logic [1:0] first_idx;
    logic [1:0] next_idx;
    logic       has_next;

    // Downward iteration leaves the lowest qualifying index as the final assignment.
    always_comb begin
        first_idx = 2'd0;
        next_idx  = 2'd0;
        has_next  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = 2'(i);
            end
            if (mask_lat[i] && (i > int'(sel))) begin
                next_idx = 2'(i);
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            sel      <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            sample   <= 4'b0000;
            mask_lat <= 4'b0000;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (mask != 4'b0000) begin
                            mask_lat <= mask;
                            sel      <= first_idx;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= StScan;
                        end else begin
                            // Empty scan completes immediately.
                            done <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    if (cnt == LastCnt) begin
                        sample[sel] <= mux_in;
                        cnt         <= '0;
                        if (has_next) begin
                            sel <= next_idx;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Scoreboard bench for sel_scan_ctrl: completion expectations are queued by the
// stimulus and popped by a monitor whenever a DONE pulse appears.
module tb_sel_scan_ctrl;

    typedef struct packed {
        logic [3:0] sample;
        logic [1:0] sel;
    } exp_t;

    logic       clk;
    logic       rst_n;

    // DWELL=4 instance
    logic       start, mux_in, busy, done;
    logic [3:0] mask, sample, sel_in;
    logic [1:0] sel;

    // DWELL=1 instance
    logic       start1, mux_in1, busy1, done1;
    logic [3:0] mask1, sample1, sel_in1;
    logic [1:0] sel1;

    exp_t q4[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    assign mux_in  = sel_in[sel];
    assign mux_in1 = sel_in1[sel1];

    sel_scan_ctrl #(.DWELL(4), .CW(8)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mask   (mask),
        .mux_in (mux_in),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .sample (sample)
    );

    sel_scan_ctrl #(.DWELL(1), .CW(8)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .mask   (mask1),
        .mux_in (mux_in1),
        .sel    (sel1),
        .busy   (busy1),
        .done   (done1),
        .sample (sample1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every DONE pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q4.size() == 0) begin
                check("dwell4 unexpected done", 8'(done), 8'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("dwell4 done sample", 8'(sample), 8'(e.sample));
                check("dwell4 done sel", 8'(sel), 8'(e.sel));
                check("dwell4 done busy", 8'(busy), 8'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                check("dwell1 unexpected done", 8'(done1), 8'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dwell1 done sample", 8'(sample1), 8'(e.sample));
                check("dwell1 done sel", 8'(sel1), 8'(e.sel));
                check("dwell1 done busy", 8'(busy1), 8'd0);
            end
        end
    end

    // Starts a DWELL=4 scan from a negedge and traces SEL/BUSY for k channels.
    // Returns at the negedge following the DONE edge. glitch>=0 raises START and
    // sets MASK=0001 on that cycle and leaves them asserted.
    task automatic scan4(input logic [3:0] m, input logic [7:0] seq, input int k,
                         input int glitch);
        start = 1'b1;
        mask  = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 4 * k; n++) begin
            check("dwell4 trace sel", 8'(sel), 8'(seq[2 * (n / 4) +: 2]));
            check("dwell4 trace busy", 8'(busy), 8'd1);
            if (n == glitch) begin
                start = 1'b1;
                mask  = 4'b0001;
            end
            @(negedge clk);
        end
        check("dwell4 busy after scan", 8'(busy), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        mask    = 4'b0000;
        sel_in  = 4'b0101;
        start1  = 1'b0;
        mask1   = 4'b0000;
        sel_in1 = 4'b0010;
        #3;
        check("reset sel", 8'(sel), 8'd0);
        check("reset busy", 8'(busy), 8'd0);
        check("reset done", 8'(done), 8'd0);
        check("reset sample", 8'(sample), 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full scan: A=1,B=0,C=1,D=0
        sel_in = 4'b0101;
        q4.push_back('{sample: 4'b0101, sel: 2'd3});
        scan4(4'b1111, 8'b11_10_01_00, 4, -1);
        @(negedge clk);
        check("idle sel holds", 8'(sel), 8'd3);

        // Sparse mask, disabled channels keep prior values
        sel_in = 4'b1111;
        q4.push_back('{sample: 4'b1111, sel: 2'd3});
        scan4(4'b1010, 8'b0000_11_01, 2, -1);
        @(negedge clk);

        // Empty mask: DONE one cycle after E0, nothing else moves
        q4.push_back('{sample: 4'b1111, sel: 2'd3});
        start = 1'b1;
        mask  = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("empty busy", 8'(busy), 8'd0);
        check("empty done", 8'(done), 8'd1);
        @(negedge clk);
        check("empty busy later", 8'(busy), 8'd0);
        check("empty done drops", 8'(done), 8'd0);

        // START/MASK mid-scan ignored; START held through DONE starts a new scan
        sel_in = 4'b1010;
        q4.push_back('{sample: 4'b1010, sel: 2'd3});
        q4.push_back('{sample: 4'b1010, sel: 2'd0});
        scan4(4'b1111, 8'b11_10_01_00, 4, 4);
        @(negedge clk);
        check("restart busy", 8'(busy), 8'd1);
        check("restart sel", 8'(sel), 8'd0);
        check("restart done low", 8'(done), 8'd0);
        start = 1'b0;
        mask  = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            check("restart hold busy", 8'(busy), 8'd1);
        end
        @(negedge clk);
        check("restart end busy", 8'(busy), 8'd0);
        @(negedge clk);

        // Asynchronous reset mid-scan
        sel_in = 4'b0101;
        start  = 1'b1;
        mask   = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre-reset sel", 8'(sel), 8'd1);
        check("pre-reset sample", 8'(sample), 8'b1011);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset sel", 8'(sel), 8'd0);
        check("async reset busy", 8'(busy), 8'd0);
        check("async reset sample", 8'(sample), 8'd0);
        check("async reset done", 8'(done), 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q4.push_back('{sample: 4'b0101, sel: 2'd3});
        scan4(4'b1111, 8'b11_10_01_00, 4, -1);
        @(negedge clk);

        // DWELL=1 instance: one channel per cycle
        q1.push_back('{sample: 4'b0010, sel: 2'd2});
        start1 = 1'b1;
        mask1  = 4'b0111;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 3; n++) begin
            check("dwell1 trace sel", 8'(sel1), 8'(n));
            check("dwell1 trace busy", 8'(busy1), 8'd1);
            @(negedge clk);
        end
        check("dwell1 busy after", 8'(busy1), 8'd0);
        repeat (2) @(negedge clk);

        check("dwell4 pending done", 8'(q4.size()), 8'd0);
        check("dwell1 pending done", 8'(q1.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_scan_ctrl.md
Name: sel_scan_ctrl

Overview:
Sequential channel scanner that drives the 2-bit SEL of the 4:1 selector stage and consumes its single-bit OUT. On a START request it walks the enabled channels in ascending order, holds each for DWELL cycles, and captures the selector output into a per-channel sample register. It signals completion with a one-cycle DONE pulse. It sits directly upstream (SEL) and downstream (OUT) of the 4:1 selector.

Parameters:
DWELL, 4, cycles SEL is held on each enabled channel before capture; legal range 1..2**CW
CW, 8, width of the internal dwell counter

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous reset, active-low
START  input  1  scan request, sampled only in IDLE
MASK  input  4  channel enables, bit i = channel i (i=SEL code); latched on accepted START
MUX_IN  input  1  selector OUT fed back for capture
SEL  output  2  channel select to the 4:1 selector
BUSY  output  1  high while a scan is in progress
DONE  output  1  one-cycle pulse at scan completion
SAMPLE  output  4  bit i = last value captured from channel i

Behaviour:
- Interface: one clock (CLK); reset RST_N is asynchronous and active-low.
- Reset (RST_N=0, takes effect immediately, independent of CLK): state=IDLE, SEL=2'b00, BUSY=0, DONE=0, SAMPLE=4'b0000, latched mask=0, counter=0.
- States: IDLE, SCAN.
- IDLE: SEL holds its last value. DONE is 0 unless it is the pulse cycle.
- IDLE, START=1, MASK!=0 at edge E0: latch MASK, SEL=lowest set bit index, counter=0, BUSY=1, go SCAN.
- IDLE, START=1, MASK=0 at edge E0: stay IDLE, DONE=1 for exactly one cycle after E0. BUSY stays 0; SAMPLE and SEL unchanged.
- SCAN, each edge: if counter==DWELL-1, then SAMPLE[SEL]<=MUX_IN, counter<=0, and advance.
  - Advance: SEL<=next higher set bit of latched mask. If no higher bit is set: go IDLE, BUSY<=0, DONE<=1 (one cycle).
  - Otherwise counter<=counter+1.
- Timing: for k enabled channels, the capture of the j-th channel (j=1..k) occurs at edge E0+j*DWELL. BUSY is high from E0 to E0+k*DWELL, and falls on the same edge that DONE rises. SAMPLE update is visible the cycle after its capture edge.
- Order is strictly ascending channel index; disabled channels are skipped with no dead cycles. SAMPLE bits of disabled channels retain their prior values.
- START during SCAN: ignored. No queuing.
- MASK changes during SCAN: ignored; the latched copy is used.
- START in the DONE-pulse cycle: state is IDLE, so it is accepted normally. DONE drops the next cycle; BUSY rises.
- DWELL=1: one capture per cycle; SEL changes every edge.
- Reset mid-scan: immediate return to reset values. A partial scan produces no DONE pulse. SAMPLE is cleared.
- Counter never exceeds DWELL-1; no wrap.

Test Plan:
- Reset, then DWELL=4, MASK=4'b1111, START at E0, MUX_IN=~SEL[0] (selector inputs A=1,B=0,C=1,D=0) -> SEL 0,1,2,3 each held 4 cycles; SAMPLE=4'b0101 after E0+16; DONE single pulse after E0+16; BUSY high E0..E0+16.
- MASK=4'b1010, DWELL=4, MUX_IN=1 -> SEL goes 1 then 3, with no visit to 0 or 2; SAMPLE[1]=SAMPLE[3]=1 while SAMPLE[0], SAMPLE[2] keep prior values; DONE after E0+8.
- MASK=4'b0000 with START -> DONE pulse one cycle after E0; BUSY never asserts; SEL and SAMPLE unchanged.
- Mid-scan (E0+5), set START=1 and MASK=4'b0001 -> both ignored; scan completes with the original mask and timing. START held high across the DONE cycle -> new scan accepted on that edge.
- DWELL=1, MASK=4'b0111 -> SEL 0,1,2 on consecutive cycles; DONE after E0+3.
- Assert RST_N=0 asynchronously at E0+6 of a full scan -> SEL=0, BUSY=0, SAMPLE=0 immediately; no DONE pulse; after release, a fresh START completes normally.
